// File: rtl/rv_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv_mem_pkg
//   Shared types and defaults for the data-memory store buffer.
//   - store_entry_t : one buffered word store {addr, data}
//   - drain_state_t : drain FSM states (IDLE, REQ)
//   - SB_DEPTH_DEFAULT / SB_ADDR_W / SB_DATA_W : default geometry.
//     The entry struct is sized from SB_ADDR_W / SB_DATA_W, so the store
//     buffer's ADDR_W / DATA_W parameters must match these.
//   - word_match() : word-granular address compare (ignores addr[1:0])
// ---------------------------------------------------------------------------
package rv_mem_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ADDR_W        = 32;
  localparam int SB_DATA_W        = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } store_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

  function automatic logic word_match(input logic [SB_ADDR_W-1:0] a,
                                      input logic [SB_ADDR_W-1:0] b);
    return a[SB_ADDR_W-1:2] == b[SB_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// ---------------------------------------------------------------------------
// sb_fifo
//   Circular storage for the store buffer: entry array, read/write pointers
//   and occupancy count. The caller guarantees push only when there is room
//   (or a pop on the same edge) and pop only when non-empty.
//   Ports:
//     clk, reset     : clock, asynchronous active-low reset
//     push, push_entry : write push_entry at wr_ptr on this edge
//     pop            : retire the head entry on this edge
//     head, head_next: entries at rd_ptr and rd_ptr+1
//     entries        : whole storage array (for load forwarding)
//     rd_ptr, count  : head index and number of occupied entries
// ---------------------------------------------------------------------------
module sb_fifo
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  store_entry_t       push_entry,
  input  logic               pop,
  output store_entry_t       head,
  output store_entry_t       head_next,
  output store_entry_t       entries [DEPTH],
  output logic [PTR_W-1:0]   rd_ptr,
  output logic [CNT_W-1:0]   count
);

  store_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;

  // NOTE: storage is deliberately not reset; count alone says which slots
  // are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: all sequential state uses non-blocking assignment so every
  // register samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + PTR_W'(1)];
  assign entries   = mem;

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Write buffer between the core data port and a slower memory bus.
//   Accepts one store per cycle (no back-pressure; stores that find the
//   buffer full are dropped and latch 'overflow'), drains entries in order
//   over a req/gnt handshake, and optionally forwards pending store data to
//   loads.
//   Build option: define STORE_FWD_EN to enable load forwarding; otherwise
//   ld_data is mem_rdata and no address comparators exist.
//   Ports:
//     clk, reset                  : clock, asynchronous active-low reset
//     st_valid, st_addr, st_data  : store from the core
//     ld_addr, mem_rdata, ld_data : load address, raw memory data, result
//     bus_req, bus_addr, bus_wdata, bus_gnt : drain handshake
//     full, empty, overflow, count: status
// ---------------------------------------------------------------------------
module store_buffer
  import rv_mem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [CNT_W-1:0]  count
);

  drain_state_t     state_q, state_d;
  store_entry_t     head, head_next, load_entry;
  store_entry_t     entries [DEPTH];
  store_entry_t     push_entry;
  logic [PTR_W-1:0] rd_ptr;
  logic             push, pop, load_bus;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A full buffer still accepts a store when the head retires on the same
  // edge: the new entry lands in the slot being freed (wr_ptr == rd_ptr).
  assign push       = st_valid && (!full || pop);
  assign push_entry = '{addr: st_addr, data: st_data};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_next  (head_next),
    .entries    (entries),
    .rd_ptr     (rd_ptr),
    .count      (count)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    load_bus   = 1'b0;
    load_entry = head;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          load_bus = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          pop = 1'b1;
          // Entry behind the one just granted goes straight onto the bus.
          if (count > CNT_W'(1)) begin
            load_bus   = 1'b1;
            load_entry = head_next;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bus_addr  <= '0;
      bus_wdata <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_bus) begin
        bus_addr  <= load_entry.addr;
        bus_wdata <= load_entry.data;
      end
      if (st_valid && !push) overflow <= 1'b1;
    end
  end

  // Decoded straight from the state flop, so reset drops it asynchronously.
  assign bus_req = (state_q == REQ);

`ifdef STORE_FWD_EN
  // Walk entries oldest to youngest; the last match wins, i.e. the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    ld_data = mem_rdata;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && word_match(entries[idx].addr, ld_addr))
        ld_data = entries[idx].data;
    end
  end
`else
  assign ld_data = mem_rdata;

  logic fwd_unused;
  always_comb begin
    fwd_unused = ^{ld_addr, rd_ptr};
    for (int i = 0; i < DEPTH; i++) fwd_unused = fwd_unused ^ (^entries[i]);
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//   Queue-based reference model of the store buffer, compared against the
//   DUT on every falling edge, plus directed scenarios with literal values.
//   Build option: STORE_FWD_EN selects the forwarding expectations.
// ---------------------------------------------------------------------------
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  logic [31:0] ld_addr = '0, mem_rdata = '0;
  logic [31:0] ld_data;
  logic        bus_req;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        full, empty, overflow;
  logic [2:0]  count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .ld_addr   (ld_addr),
    .mem_rdata (mem_rdata),
    .ld_data   (ld_data),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_gnt   (bus_gnt),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];        // pending stores, oldest first (includes the one on the bus)
  bit          m_req;
  logic [31:0] m_addr, m_wdata;
  bit          m_ovf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_req   = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_ovf   = 1'b0;
    end else begin
      bit   do_pop, do_push;
      ent_t e;
      do_pop  = m_req && bus_gnt;
      do_push = st_valid && ((q.size() < DEPTH) || do_pop);
      if (st_valid && !do_push) m_ovf = 1'b1;
      if (!m_req) begin
        if (q.size() > 0) begin
          m_req   = 1'b1;
          m_addr  = q[0].addr;
          m_wdata = q[0].data;
        end
      end else if (bus_gnt) begin
        if (q.size() > 1) begin
          m_addr  = q[1].addr;
          m_wdata = q[1].data;
        end else begin
          m_req = 1'b0;
        end
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.addr = st_addr;
        e.data = st_data;
        q.push_back(e);
      end
    end
  end

  function automatic logic [31:0] model_ld();
    logic [31:0] r;
    r = mem_rdata;
`ifdef STORE_FWD_EN
    foreach (q[i]) begin
      logic [31:0] a;
      a = q[i].addr;
      if (a[31:2] == ld_addr[31:2]) r = q[i].data;
    end
`endif
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  logic [31:0] granted[$];

  always @(negedge clk) begin
    check("bus_req",   32'(bus_req),  32'(m_req));
    check("bus_addr",  bus_addr,      m_addr);
    check("bus_wdata", bus_wdata,     m_wdata);
    check("count",     32'(count),    32'(q.size()));
    check("full",      32'(full),     32'(q.size() == DEPTH));
    check("empty",     32'(empty),    32'(q.size() == 0));
    check("overflow",  32'(overflow), 32'(m_ovf));
    check("ld_data",   ld_data,       model_ld());
    if (reset && bus_req && bus_gnt) granted.push_back(bus_addr);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic g);
    @(posedge clk);
    #2;
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    bus_gnt  = g;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 reset = 1'b0;
    #3 reset = 1'b1;
  endtask

  initial begin
    ld_addr   = 32'hFFFF_FF00;
    mem_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_empty", 32'(empty),    32'd1);
    check("rst_count", 32'(count),    32'd0);
    check("rst_req",   32'(bus_req),  32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_ld",    ld_data,       32'h1234_5678);

    // Single store, grant withheld for three REQ cycles.
    drive(1, 32'h100, 32'hDEAD_BEEF, 0);
    drive(0, 0, 0, 0);
    check("t1_count1", 32'(count),   32'd1);
    check("t1_noreq",  32'(bus_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, (i == 2));
      check("t1_req",   32'(bus_req), 32'd1);
      check("t1_addr",  bus_addr,     32'h100);
      check("t1_wdata", bus_wdata,    32'hDEAD_BEEF);
    end
    drive(0, 0, 0, 0);
    check("t1_req_off", 32'(bus_req), 32'd0);
    check("t1_empty",   32'(empty),   32'd1);

    // Back-to-back stores with grant tied high.
    granted.delete();
    for (int i = 0; i < 10; i++) begin
      drive(i < 4, 32'(4 * i), 32'hA0 + 32'(i), 1);
      check("t2_cnt_le2", 32'(count <= 3'd2), 32'd1);
    end
    check("t2_ndrain", 32'(granted.size()), 32'd4);
    for (int i = 0; i < 4 && i < granted.size(); i++)
      check("t2_order", granted[i], 32'(4 * i));
    check("t2_ovf", 32'(overflow), 32'd0);
    drive(0, 0, 0, 0);

    // Fill with grant low, fifth store dropped, overflow sticky.
    for (int i = 0; i < 5; i++) drive(1, 32'h40 + 32'(4 * i), 32'hB0 + 32'(i), 0);
    drive(0, 0, 0, 0);
    check("t3_full",  32'(full),     32'd1);
    check("t3_count", 32'(count),    32'd4);
    check("t3_ovf",   32'(overflow), 32'd1);
    granted.delete();
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    check("t3_ovf_hold", 32'(overflow), 32'd1);
    check("t3_empty",    32'(empty),    32'd1);
    check("t3_ndrain",   32'(granted.size()), 32'd4);
    if (granted.size() == 4) check("t3_last", granted[3], 32'h4C);

    // Full buffer: push and grant on the same edge.
    reset_pulse();
    for (int i = 0; i < 4; i++) drive(1, 32'h70 + 32'(4 * i), 32'hC0 + 32'(i), 0);
    granted.delete();
    drive(1, 32'h60, 32'hC4, 1);
    drive(0, 0, 0, 0);
    check("t4_count", 32'(count),    32'd4);
    check("t4_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    check("t4_ndrain", 32'(granted.size()), 32'd5);
    if (granted.size() == 5) check("t4_wrapped", granted[4], 32'h60);

    // Forwarding: youngest matching word wins.
    reset_pulse();
    drive(1, 32'h200, 32'h11, 0);
    drive(1, 32'h200, 32'h22, 0);
    drive(0, 0, 0, 0);
    ld_addr   = 32'h202;
    mem_rdata = 32'h99;
    #1;
`ifdef STORE_FWD_EN
    check("t5_fwd_hit", ld_data, 32'h22);
`else
    check("t5_fwd_hit", ld_data, 32'h99);
`endif
    ld_addr = 32'h204;
    #1 check("t5_fwd_miss", ld_data, 32'h99);

    // Reset pulse while draining with three entries pending.
    reset_pulse();
    for (int i = 0; i < 3; i++) drive(1, 32'h80 + 32'(4 * i), 32'hD0 + 32'(i), 0);
    drive(0, 0, 0, 0);
    check("t6_count3", 32'(count),   32'd3);
    check("t6_req",    32'(bus_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t6_req_async", 32'(bus_req), 32'd0);
    check("t6_count0",    32'(count),   32'd0);
    check("t6_empty",     32'(empty),   32'd1);
    #2 reset = 1'b1;
    granted.delete();
    drive(1, 32'h300, 32'hE0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    check("t6_ndrain", 32'(granted.size()), 32'd1);
    if (granted.size() == 1) check("t6_addr", granted[0], 32'h300);

    // Randomized traffic against the model.
    reset_pulse();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) < 60,
            32'h400 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)),
            $urandom,
            $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 50 : 85));
      ld_addr   = 32'h400 + 32'($urandom_range(0, 9) << 2);
      mem_rdata = $urandom;
    end
    drive(0, 0, 0, 1);
    repeat (8) drive(0, 0, 0, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the RISC-V core's data-memory port (MemWrite / ALUResult / WriteData, plus ReadData back to the core).
- Accepts one store per cycle with no back-pressure, because the core has no stall input.
- Queues stores in a circular FIFO and drains them to a slower data-memory bus using a req/gnt handshake.
- Forwards buffered store data to loads, so the core reads its own pending writes.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of 2 and ≥2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width (word stores only).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- st_valid  in  1  store request; connects to core MemWrite.
- st_addr  in  ADDR_W  store address; connects to core ALUResult.
- st_data  in  DATA_W  store data; connects to core WriteData.
- ld_addr  in  ADDR_W  load address; connects to core ALUResult.
- mem_rdata  in  DATA_W  raw read data from data memory.
- ld_data  out  DATA_W  load data returned to core ReadData.
- bus_req  out  1  drain request to the data-memory bus.
- bus_addr  out  ADDR_W  drain address.
- bus_wdata  out  DATA_W  drain data.
- bus_gnt  in  1  bus accepts the current request on this edge.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a store was dropped.
- count  out  $clog2(DEPTH+1)  current number of occupied entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE.
  - bus_req=0, bus_addr=0, bus_wdata=0, overflow=0.
  - empty=1, full=0.
  - ld_data follows mem_rdata.
- Reset asserted mid-drain: bus_req drops immediately (asynchronously) and all buffered stores are discarded. This is intentional; the bus must tolerate req falling without a grant.
- Push:
  - Occurs on a rising edge when st_valid=1 and (count<DEPTH or a pop occurs on the same edge).
  - Writes {st_addr, st_data} at wr_ptr; wr_ptr increments modulo DEPTH.
- Drop: st_valid=1 with count==DEPTH and no pop on that edge. The store is discarded, overflow is set to 1, and overflow holds until reset.
- Pop: occurs on a rising edge when FSM=REQ and bus_gnt=1; rd_ptr increments modulo DEPTH.
- Count update on each edge: count += push − pop. Simultaneous push and pop leaves count unchanged.
- Drain FSM, registered outputs:
  - IDLE: bus_req=0. If count>0, load the head entry into bus_addr/bus_wdata and go to REQ.
  - REQ: bus_req=1. bus_addr and bus_wdata are held stable until a grant. On bus_gnt=1: pop; if (count−1)>0, load the next entry (rd_ptr+1) and stay in REQ (back-to-back drains), otherwise go to IDLE.
  - bus_gnt is ignored in IDLE.
- Latency:
  - A store pushed into an empty buffer at edge t produces bus_req=1 after edge t+1.
  - Minimum occupancy per store is 2 cycles.
  - Steady-state throughput with bus_gnt tied high is 1 store per cycle.
- Pointers wrap at DEPTH−1 → 0 without a gap; a full buffer has wr_ptr == rd_ptr.
- Addresses are compared and stored as full words; st_addr[1:0] is carried through unchanged.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined:
  - ld_data is combinational. It returns the youngest valid entry whose addr[ADDR_W-1:2] matches ld_addr[ADDR_W-1:2]; otherwise it returns mem_rdata.
  - The entry currently presented on the bus counts as valid until it is popped.
  - A store being pushed on the same cycle is not forwarded; it becomes visible from the next cycle.
- Undefined:
  - ld_data = mem_rdata unconditionally and no comparators are synthesised.
  - Software must not load an address with a pending store, e.g. it must poll empty first.

Decomposition:
- Package rv_mem_pkg:
  - store_entry_t packed struct {addr, data}.
  - drain_state_t enum {IDLE, REQ}.
  - localparam SB_DEPTH_DEFAULT = 4.
- Sub-module sb_fifo:
  - Holds the circular storage, pointers and count.
  - Exposes push/pop, head entry, head+1 entry and the entry array for forwarding.
- store_buffer holds the drain FSM, overflow flag and forwarding mux.

Test Plan:
- Single store, bus_gnt held 0 for 3 cycles then 1: push addr 0x100, data 0xDEADBEEF.
  - Required: bus_req=1 from edge t+1; bus_addr/bus_wdata stable at 0x100/0xDEADBEEF until the grant edge.
  - Then bus_req=0, empty=1.
- 4 back-to-back stores, bus_gnt tied 1: addresses 0x0, 0x4, 0x8, 0xC.
  - Required: drained in order on 4 consecutive edges; count never exceeds 2; no overflow.
- Fill buffer, bus_gnt=0, then 5th store 0x50:
  - Required: full=1, 5th store dropped, overflow=1 and held.
  - After draining, overflow is still 1 until reset.
- Full buffer, push and grant on the same edge:
  - Required: count stays 4, the new entry lands at the wrapped wr_ptr, overflow stays 0.
- STORE_FWD_EN defined: store 0x11 then 0x22 to 0x200, bus_gnt=0, then ld_addr=0x202 with mem_rdata=0x99.
  - Required: ld_data=0x22. With ld_addr=0x204: ld_data=0x99.
- Reset pulse while in REQ with count=3:
  - Required: bus_req=0 before the next clock edge, count=0, empty=1; a normal store after release drains correctly.
